// File: rtl/ledout_sequencer.sv
// Pattern sequencer stepping a table of LEDOUT words on a prescaled tick, one-shot or looping.
// Optional LEDSEQ_PAUSE_EN adds a pause input that freezes the running sequence.
module ledout_sequencer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DWELL_W = 16,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned NW     = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [7:0]         cfg_ledout,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [NW-1:0]      num_steps,
  input  logic               loop_en,
  input  logic               start,
  input  logic               stop,
  input  logic [7:0]         idle_ledout,
`ifdef LEDSEQ_PAUSE_EN
  input  logic               pause,
`endif
  output logic [7:0]         ledout_reg,
  output logic               busy,
  output logic [AW-1:0]      step_idx,
  output logic               done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e               state_q, state_d;
  logic [7:0]           led_tbl_q [DEPTH];
  logic [7:0]           led_tbl_d [DEPTH];
  logic [DWELL_W-1:0]   dwell_tbl_q [DEPTH];
  logic [DWELL_W-1:0]   dwell_tbl_d [DEPTH];
  logic [7:0]           ledout_q, ledout_d;
  logic                 busy_q, busy_d;
  logic [AW-1:0]        step_q, step_d;
  logic                 done_q, done_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [NW-1:0]        n_q, n_d;
  logic                 loop_q, loop_d;
  logic                 pause_w;
  logic                 last_step;
  logic [AW-1:0]        step_inc;

`ifdef LEDSEQ_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  assign step_inc  = step_q + AW'(1);
  // n_q is never zero while running, so n_q-1 always fits the index width.
  assign last_step = (step_q == AW'(n_q - NW'(1)));

  always_comb begin
    state_d     = state_q;
    led_tbl_d   = led_tbl_q;
    dwell_tbl_d = dwell_tbl_q;
    ledout_d    = ledout_q;
    busy_d      = busy_q;
    step_d      = step_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    n_d         = n_q;
    loop_d      = loop_q;

    if (cfg_we && !busy_q) begin
      led_tbl_d[cfg_addr]   = cfg_ledout;
      dwell_tbl_d[cfg_addr] = cfg_dwell;
    end

    unique case (state_q)
      StIdle: begin
        ledout_d = idle_ledout;
        busy_d   = 1'b0;
        step_d   = '0;
        if (start && !stop && (num_steps != '0)) begin
          state_d  = StRun;
          n_d      = (num_steps > NW'(DEPTH)) ? NW'(DEPTH) : num_steps;
          loop_d   = loop_en;
          ledout_d = led_tbl_q[0];
          cnt_d    = dwell_tbl_q[0];
          busy_d   = 1'b1;
        end
      end
      StRun: begin
        if (stop) begin
          state_d  = StIdle;
          ledout_d = idle_ledout;
          busy_d   = 1'b0;
          step_d   = '0;
          cnt_d    = '0;
        end else if (tick && !pause_w) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else if (!last_step) begin
            step_d   = step_inc;
            ledout_d = led_tbl_q[step_inc];
            cnt_d    = dwell_tbl_q[step_inc];
          end else if (loop_q) begin
            step_d   = '0;
            ledout_d = led_tbl_q[0];
            cnt_d    = dwell_tbl_q[0];
          end else begin
            state_d  = StIdle;
            ledout_d = idle_ledout;
            busy_d   = 1'b0;
            step_d   = '0;
            done_d   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ledout_q <= 8'h00;
      busy_q   <= 1'b0;
      step_q   <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      n_q      <= '0;
      loop_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        led_tbl_q[i]   <= '0;
        dwell_tbl_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ledout_q    <= ledout_d;
      busy_q      <= busy_d;
      step_q      <= step_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      loop_q      <= loop_d;
      led_tbl_q   <= led_tbl_d;
      dwell_tbl_q <= dwell_tbl_d;
    end
  end

  assign ledout_reg = ledout_q;
  assign busy       = busy_q;
  assign step_idx   = step_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ledout_sequencer.sv
// Directed self-checking bench for ledout_sequencer (pause checks built when LEDSEQ_PAUSE_EN is set).
module tb_ledout_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_ledout;
  logic [15:0] cfg_dwell;
  logic [3:0]  num_steps;
  logic        loop_en;
  logic        start;
  logic        stop;
  logic [7:0]  idle_ledout;
  logic        pause;
  logic [7:0]  ledout_reg;
  logic        busy;
  logic [2:0]  step_idx;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_led  [6] = '{8'h01, 8'h01, 8'h04, 8'h10, 8'h10, 8'h01};
  logic [2:0] exp_step [6] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd0};

  ledout_sequencer #(
    .DEPTH  (8),
    .DWELL_W(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_ledout (cfg_ledout),
    .cfg_dwell  (cfg_dwell),
    .num_steps  (num_steps),
    .loop_en    (loop_en),
    .start      (start),
    .stop       (stop),
    .idle_ledout(idle_ledout),
`ifdef LEDSEQ_PAUSE_EN
    .pause      (pause),
`endif
    .ledout_reg (ledout_reg),
    .busy       (busy),
    .step_idx   (step_idx),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] l, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_ledout = l; cfg_dwell = d;
    clk1();
    cfg_we = 1'b0;
  endtask

  task automatic go(input logic [3:0] n, input logic lp);
    start = 1'b1; num_steps = n; loop_en = lp;
    clk1();
    start = 1'b0;
  endtask

  // Tick every 4 clocks; returns just after the edge that sampled the tick.
  task automatic tk();
    repeat (3) clk1();
    tick = 1'b1;
    clk1();
    tick = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] l, input logic [2:0] s,
                           input logic b, input logic d);
    chk({tag, ".led"},  {24'h0, ledout_reg}, {24'h0, l});
    chk({tag, ".step"}, {29'h0, step_idx},   {29'h0, s});
    chk({tag, ".busy"}, {31'h0, busy},       {31'h0, b});
    chk({tag, ".done"}, {31'h0, done},       {31'h0, d});
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_ledout = '0; cfg_dwell = '0;
    num_steps = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0; idle_ledout = 8'hAA;
    pause = 1'b0;
    clk1();
    clk1();
    chk_state("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    clk1();
    chk("idle_track0", {24'h0, ledout_reg}, 32'hAA);
    idle_ledout = 8'h55;
    #1;
    chk("idle_hold", {24'h0, ledout_reg}, 32'hAA);
    clk1();
    chk("idle_track1", {24'h0, ledout_reg}, 32'h55);
    idle_ledout = 8'hAA;
    clk1();

    wr(3'd0, 8'h01, 16'd2);
    wr(3'd1, 8'h04, 16'd0);
    wr(3'd2, 8'h10, 16'd1);

    // One-shot
    go(4'd3, 1'b0);
    chk_state("os_start", 8'h01, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tk();
      chk_state($sformatf("os_tick%0d", i + 1), exp_led[i], exp_step[i], 1'b1, 1'b0);
    end
    tk();
    chk_state("os_done", 8'hAA, 3'd0, 1'b0, 1'b1);
    clk1();
    chk_state("os_after", 8'hAA, 3'd0, 1'b0, 1'b0);

    // Loop with a table write attempted while running
    go(4'd3, 1'b1);
    chk_state("lp_start", 8'h01, 3'd0, 1'b1, 1'b0);
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 6; i++) begin
        tk();
        chk_state($sformatf("lp%0d_tick%0d", l, i + 1), exp_led[i], exp_step[i], 1'b1, 1'b0);
        if (l == 0 && i == 0) wr(3'd1, 8'hFF, 16'd0);
      end
    end
    stop = 1'b1;
    clk1();
    stop = 1'b0;
    chk_state("lp_stop", 8'hAA, 3'd0, 1'b0, 1'b0);
    clk1();
    chk("lp_stop_nodone", {31'h0, done}, 32'h0);

    // start+stop in idle
    start = 1'b1; stop = 1'b1; num_steps = 4'd3; loop_en = 1'b0;
    clk1();
    start = 1'b0; stop = 1'b0;
    chk_state("ss_idle", 8'hAA, 3'd0, 1'b0, 1'b0);

    // start with num_steps=0
    go(4'd0, 1'b0);
    chk_state("n0_start", 8'hAA, 3'd0, 1'b0, 1'b0);

    // stop coinciding with the final tick
    go(4'd3, 1'b0);
    for (int i = 0; i < 5; i++) tk();
    chk_state("st_pre", 8'h10, 3'd2, 1'b1, 1'b0);
    repeat (3) clk1();
    tick = 1'b1; stop = 1'b1;
    clk1();
    tick = 1'b0; stop = 1'b0;
    chk_state("st_final", 8'hAA, 3'd0, 1'b0, 1'b0);
    clk1();
    chk("st_nodone", {31'h0, done}, 32'h0);

    // num_steps beyond DEPTH clamps to 8
    for (int i = 0; i < 8; i++) wr(3'(i), 8'h30 + 8'(i), 16'd0);
    go(4'd15, 1'b0);
    chk_state("cl_start", 8'h30, 3'd0, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) begin
      tk();
      chk_state($sformatf("cl_step%0d", i), 8'h30 + 8'(i), 3'(i), 1'b1, 1'b0);
    end
    tk();
    chk_state("cl_done", 8'hAA, 3'd0, 1'b0, 1'b1);

    // Reset mid-run clears the table
    go(4'd8, 1'b0);
    tk();
    chk_state("rr_step1", 8'h31, 3'd1, 1'b1, 1'b0);
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    chk_state("rr_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    clk1();
    go(4'd8, 1'b0);
    chk_state("rr_run0", 8'h00, 3'd0, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) begin
      tk();
      chk_state($sformatf("rr_run%0d", i), 8'h00, 3'(i), 1'b1, 1'b0);
    end
    tk();
    chk_state("rr_done", 8'hAA, 3'd0, 1'b0, 1'b1);

`ifdef LEDSEQ_PAUSE_EN
    wr(3'd0, 8'h5A, 16'd3);
    wr(3'd1, 8'hA5, 16'd0);
    go(4'd2, 1'b0);
    tk();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tk();
      chk_state($sformatf("pz_hold%0d", i), 8'h5A, 3'd0, 1'b1, 1'b0);
    end
    pause = 1'b0;
    tk();
    tk();
    chk_state("pz_resume", 8'h5A, 3'd0, 1'b1, 1'b0);
    tk();
    chk_state("pz_adv", 8'hA5, 3'd1, 1'b1, 1'b0);
    tk();
    chk_state("pz_done", 8'hAA, 3'd0, 1'b0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
